regwr_arbiter: RTL

Round-robin arbiter that shares the register file's single write port among `NREQ` writeback requesters (ALU, load, link-register, …). Each cycle it grants at most one requester, registers that requester's destination address and data, and drives a one-hot 32-entry write-enable vector into the register array. It sits between the pipeline writeback sources and the 32×64 register file. It owns the `decoder5x32` instance that turns the registered 5-bit address into per-register enables.

---
 rtl/regwr_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/regwr_arbiter.sv
// Round-robin arbiter for the register-file write port, with registered write
// stage and 5-to-32 enable decoder. Optional XZR write drop: REGWR_ARB_XZR_DROP_EN.

module decoder5x32 (
   input  logic [4:0]  in_addr,
   input  logic        en,
   output logic [31:0] onehot
);

   // One-hot decode of the write address, gated by the strobe
   always_comb begin
      onehot = 32'h0000_0000;
      if (en) begin
         onehot[in_addr] = 1'b1;
      end else begin
         onehot = 32'h0000_0000;
      end
   end

endmodule

module regwr_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*5-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic              stall,
   output logic [NREQ-1:0]   gnt,
   output logic              wr_en,
   output logic [4:0]        wr_addr,
   output logic [DW-1:0]     wr_data,
   output logic [31:0]       wr_onehot
);

   localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [4:0] XZR_ADDR = 5'd31;

   logic [PW-1:0]   ptr_q, ptr_d;
   logic            wr_en_q, wr_en_d;
   logic [4:0]      wr_addr_q, wr_addr_d;
   logic [DW-1:0]   wr_data_q, wr_data_d;

   logic [NREQ-1:0] gnt_s;
   logic [PW-1:0]   gnt_idx_s;
   logic            xfer_s;
   logic [4:0]      sel_addr_s;
   logic [DW-1:0]   sel_data_s;

   // Index base+off wrapped into 0..NREQ-1 (off never exceeds NREQ)
   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NREQ) begin
         sum = sum - NREQ;
      end else begin
         sum = sum;
      end
      return PW'(sum);
   endfunction

   // Grant the first requester at or above ptr, wrapping; nothing while stalled or in reset
   always_comb begin
      gnt_s     = '0;
      gnt_idx_s = '0;
      xfer_s    = 1'b0;
      if (reset_n && !stall) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!xfer_s && req[wrap_idx(ptr_q, k)]) begin
               xfer_s                       = 1'b1;
               gnt_idx_s                    = wrap_idx(ptr_q, k);
               gnt_s[wrap_idx(ptr_q, k)]    = 1'b1;
            end else begin
               xfer_s = xfer_s;
            end
         end
      end else begin
         gnt_s     = '0;
         gnt_idx_s = '0;
         xfer_s    = 1'b0;
      end
   end

   // Next-state for pointer and output stage
   always_comb begin
      sel_addr_s = req_addr[int'(gnt_idx_s)*5 +: 5];
      sel_data_s = req_data[int'(gnt_idx_s)*DW +: DW];
      ptr_d      = ptr_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      if (xfer_s) begin
         ptr_d     = wrap_idx(gnt_idx_s, 1);
`ifdef REGWR_ARB_XZR_DROP_EN
         // XZR writes consume the handshake but never strobe the array
         wr_en_d   = (sel_addr_s != XZR_ADDR);
`else
         wr_en_d   = 1'b1;
`endif
         wr_addr_d = sel_addr_s;
         wr_data_d = sel_data_s;
      end else begin
         ptr_d     = ptr_q;
         wr_en_d   = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= 5'd0;
         wr_data_q <= '0;
      end else begin
         ptr_q     <= ptr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   decoder5x32 u_dec (
      .in_addr (wr_addr_q),
      .en      (wr_en_q),
      .onehot  (wr_onehot)
   );

   assign gnt     = gnt_s;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

endmodule
